mux_pipe_stage: RTL and testbench

- Parametrised N-way registered multiplexer for the datapath.
- Selects one of CH data channels per beat and registers the result behind a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready path and no combinational ready chain.
- Used wherever a select must be timing-isolated, e.g. writeback and ALU operand source selection between pipeline stages, with flush support for branch redirects.

---
 rtl/mux_pipe_stage.sv | 127 ++++++++++++
 tb/tb_mux_pipe_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mux_pipe_stage
//  Purpose  : N-way registered multiplexer behind a valid/ready handshake,
//             with a 2-entry skid buffer and flush support.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_pipe_stage #(
    parameter int n    = 32,
    parameter int CH   = 4,
    parameter int SELW = $clog2(CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH*n-1:0]   in_data,
    input  logic [SELW-1:0]   sel,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [n-1:0]      out_data,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t         r_state_q;
    state_t         w_state_d;
    logic [n-1:0]   r_main_data_q;
    logic [n-1:0]   w_main_data_d;
    logic           r_main_err_q;
    logic           w_main_err_d;
    logic [n-1:0]   r_skid_data_q;
    logic [n-1:0]   w_skid_data_d;
    logic           r_skid_err_q;
    logic           w_skid_err_d;
    logic [n-1:0]   w_mux_data;
    logic           w_mux_err;
    logic           w_accept;
    logic           w_drain;

    // An unmatched select (only reachable when CH is not a power of two)
    // yields zero data flagged with err.
    always_comb begin
        w_mux_data = '0;
        w_mux_err  = 1'b1;
        for (int k = 0; k < CH; k++) begin
            if (sel == SELW'(k)) begin
                w_mux_data = in_data[k*n +: n];
                w_mux_err  = 1'b0;
            end
        end
    end

    assign in_ready  = !rst && (r_state_q != S_FULL);
    assign out_valid = (r_state_q != S_EMPTY);
    assign out_data  = r_main_data_q;
    assign out_err   = r_main_err_q;
    assign w_accept  = in_valid && in_ready;
    assign w_drain   = out_valid && out_ready;

    always_comb begin
        w_state_d     = r_state_q;
        w_main_data_d = r_main_data_q;
        w_main_err_d  = r_main_err_q;
        w_skid_data_d = r_skid_data_q;
        w_skid_err_d  = r_skid_err_q;
        if (flush) begin
            w_state_d = S_EMPTY;
        end else begin
            case (r_state_q)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state_d     = S_ONE;
                        w_main_data_d = w_mux_data;
                        w_main_err_d  = w_mux_err;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_drain) begin
                        w_main_data_d = w_mux_data;
                        w_main_err_d  = w_mux_err;
                    end else if (w_accept) begin
                        w_state_d     = S_FULL;
                        w_skid_data_d = w_mux_data;
                        w_skid_err_d  = w_mux_err;
                    end else if (w_drain) begin
                        w_state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_drain) begin
                        w_state_d     = S_ONE;
                        w_main_data_d = r_skid_data_q;
                        w_main_err_d  = r_skid_err_q;
                    end
                end
                default: begin
                    w_state_d = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_EMPTY;
            r_main_data_q <= '0;
            r_main_err_q  <= 1'b0;
            r_skid_data_q <= '0;
            r_skid_err_q  <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_main_data_q <= w_main_data_d;
            r_main_err_q  <= w_main_err_d;
            r_skid_data_q <= w_skid_data_d;
            r_skid_err_q  <= w_skid_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_pipe_stage
//  Purpose  : Scoreboard bench for mux_pipe_stage (CH=4 and CH=3 instances).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_pipe_stage;
    localparam int N = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    logic run_mon = 1'b0;

    logic [4*N-1:0] a_in_data;
    logic [1:0]     a_sel;
    logic           a_in_valid, a_in_ready, a_flush, a_out_err, a_out_valid, a_out_ready;
    logic [N-1:0]   a_out_data;

    logic [3*N-1:0] b_in_data;
    logic [1:0]     b_sel;
    logic           b_in_valid, b_in_ready, b_flush, b_out_err, b_out_valid, b_out_ready;
    logic [N-1:0]   b_out_data;

    mux_pipe_stage #(.n(N), .CH(4), .SELW(2)) dut_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .sel(a_sel), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .flush(a_flush), .out_data(a_out_data), .out_err(a_out_err),
        .out_valid(a_out_valid), .out_ready(a_out_ready));

    mux_pipe_stage #(.n(N), .CH(3), .SELW(2)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .sel(b_sel), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .flush(b_flush), .out_data(b_out_data), .out_err(b_out_err),
        .out_valid(b_out_valid), .out_ready(b_out_ready));

    int errors = 0;
    int checks = 0;
    logic [N:0] qa[$];
    logic [N:0] qb[$];
    logic       pend_a, pend_b;
    logic [N:0] pend_a_val, pend_b_val;

    // Reference select: {err, data}
    function automatic logic [N:0] ref_sel(input logic [4*N-1:0] d, input int s, input int ch);
        if (s < ch) return {1'b0, d[s*N +: N]};
        return {1'b1, {N{1'b0}}};
    endfunction

    task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Capture beats the DUT takes this cycle; they enter the scoreboard at the edge.
    always @(negedge clk) begin
        pend_a     = a_in_valid && a_in_ready && !a_flush && !rst;
        pend_a_val = ref_sel(a_in_data, int'(a_sel), 4);
        pend_b     = b_in_valid && b_in_ready && !b_flush && !rst;
        pend_b_val = ref_sel({{N{1'b0}}, b_in_data}, int'(b_sel), 3);
    end

    always @(posedge clk) begin
        if (pend_a) qa.push_back(pend_a_val);
        if (pend_b) qb.push_back(pend_b_val);
        pend_a = 1'b0;
        pend_b = 1'b0;
    end

    // Monitors: occupancy-derived handshake expectations plus head-of-queue data.
    always @(negedge clk) begin
        if (run_mon) begin
            check("a_out_valid", a_out_valid, qa.size() != 0);
            check("a_in_ready", a_in_ready, !rst && qa.size() < 2);
            if (a_out_valid && qa.size() != 0) check("a_beat", {a_out_err, a_out_data}, qa[0]);
            if (a_out_valid && a_out_ready && qa.size() != 0) void'(qa.pop_front());
            if (rst || a_flush) qa.delete();
        end
    end

    always @(negedge clk) begin
        if (run_mon) begin
            check("b_out_valid", b_out_valid, qb.size() != 0);
            check("b_in_ready", b_in_ready, !rst && qb.size() < 2);
            if (b_out_valid && qb.size() != 0) check("b_beat", {b_out_err, b_out_data}, qb[0]);
            if (b_out_valid && b_out_ready && qb.size() != 0) void'(qb.pop_front());
            if (rst || b_flush) qb.delete();
        end
    end

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer a beat on dut_a until it is taken (bounded).
    task automatic send_a(input logic [1:0] s, input logic [4*N-1:0] d);
        bit done = 0;
        a_in_valid = 1'b1;
        a_sel      = s;
        a_in_data  = d;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (a_in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_a_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
    endtask

    task automatic send_b(input logic [1:0] s, input logic [3*N-1:0] d);
        b_in_valid = 1'b1;
        b_sel      = s;
        b_in_data  = d;
        step(1);
        b_in_valid = 1'b0;
    endtask

    function automatic logic [4*N-1:0] all_ch(input logic [N-1:0] v);
        return {v, v, v, v};
    endfunction

    initial begin
        rst = 1'b1;
        a_in_data = '0; a_sel = '0; a_in_valid = 0; a_flush = 0; a_out_ready = 1;
        b_in_data = '0; b_sel = '0; b_in_valid = 0; b_flush = 0; b_out_ready = 1;
        step(1);
        run_mon = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        @(negedge clk);
        check("reset_out_data", {a_out_err, a_out_data}, '0);
        check("reset_in_ready", a_in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single beat from channel 2
        send_a(2'd2, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
        @(negedge clk);
        check("first_beat", {a_out_valid, a_out_err, a_out_data}, {1'b1, 1'b0, 32'hDEADBEEF});
        @(posedge clk);
        #1;

        // Streaming: one beat per cycle
        for (int i = 0; i < 8; i++) send_a(2'(i % 4), all_ch(32'h1000_0000 + 32'(i)));
        step(2);

        // Backpressure: A, B taken, C held upstream
        a_out_ready = 1'b0;
        send_a(2'd0, {32'h0, 32'h0, 32'h0, 32'hAAAA_0001});
        send_a(2'd1, {32'h0, 32'h0, 32'hBBBB_0002, 32'h0});
        a_in_valid = 1'b1;
        a_sel      = 2'd3;
        a_in_data  = {32'hCCCC_0003, 96'h0};
        step(3);
        a_out_ready = 1'b1;
        send_a(2'd3, {32'hCCCC_0003, 96'h0});
        step(3);

        // Flush while FULL with a beat offered
        a_out_ready = 1'b0;
        send_a(2'd1, all_ch(32'h5555_0001));
        send_a(2'd2, all_ch(32'h5555_0002));
        a_in_valid = 1'b1;
        a_flush    = 1'b1;
        step(1);
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        @(negedge clk);
        check("flush_full_valid", {a_out_valid, a_in_ready}, 2'b01);
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        send_a(2'd0, all_ch(32'h6666_0000));
        // Flush in ONE with a concurrent accept: that beat is discarded
        a_in_valid = 1'b1;
        a_sel      = 2'd1;
        a_in_data  = all_ch(32'h7777_0000);
        a_out_ready = 1'b0;
        a_flush    = 1'b1;
        step(1);
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        step(2);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            a_in_valid  = 1'($urandom_range(0, 1));
            a_sel       = 2'($urandom_range(0, 3));
            a_in_data   = {$urandom, $urandom, $urandom, $urandom};
            a_out_ready = ($urandom_range(0, 3) != 0);
            a_flush     = ($urandom_range(0, 24) == 0);
            b_in_valid  = 1'($urandom_range(0, 1));
            b_sel       = 2'($urandom_range(0, 3));
            b_in_data   = {$urandom, $urandom, $urandom};
            b_out_ready = ($urandom_range(0, 2) != 0);
            step(1);
        end
        a_in_valid = 0; a_flush = 0; a_out_ready = 1;
        b_in_valid = 0; b_out_ready = 1;
        step(3);

        // CH=3: out-of-range select, then a legal one
        send_b(2'd3, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
        @(negedge clk);
        check("b_oor_beat", {b_out_valid, b_out_err, b_out_data}, {1'b1, 1'b1, 32'h0});
        @(posedge clk);
        #1;
        send_b(2'd1, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
        @(negedge clk);
        check("b_legal_beat", {b_out_valid, b_out_err, b_out_data}, {1'b1, 1'b0, 32'h2222_2222});
        @(posedge clk);
        #1;
        step(2);

        // Reset while FULL
        a_out_ready = 1'b0;
        send_a(2'd3, all_ch(32'h9999_0001));
        send_a(2'd0, all_ch(32'h9999_0002));
        rst = 1'b1;
        step(1);
        @(negedge clk);
        check("rst_full", {a_out_valid, a_in_ready}, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        check("rst_release", {a_out_valid, a_in_ready}, 2'b01);
        @(posedge clk);
        #1;
        step(4);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL final_drain: got %0d/%0d beats outstanding expected 0/0", qa.size(), qb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
